// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo controller: bus addresses, FSM states,
// the bus request bundle and the baud divisor lookup.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    SETTLE,
    POLL,
    RD_RX,
    WR_TX
  } state_t;

  typedef struct packed {
    logic       iocs;
    logic       iorw;
    logic [1:0] addr;
    logic [7:0] wdata;
  } bus_req_t;

  function automatic logic [15:0] baud_div(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'd5208;
      2'b01:   return 16'd2604;
      2'b10:   return 16'd1302;
      default: return 16'd651;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with synchronous reset and flush; pointers wrap
// naturally, occupancy count carries one extra bit to tell full from empty.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spart_echo_ctrl.sv
// Programs the SPART baud divisor, then echoes every received byte back out
// through a small FIFO, one bus access at a time with a settle cycle between.
module spart_echo_ctrl
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  input  logic       rda,
  input  logic       tbr,
  inout  wire  [7:0] databus,
  output logic       cfg_done,
  output logic [7:0] drop_cnt
);

  state_t     state, nxt, dec_state;
  logic [1:0] cfg_sel;
  logic [15:0] div;
  logic       cfg_change, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  bus_req_t   req;

  assign div        = baud_div(cfg_sel);
  assign cfg_change = (state == POLL) && (cfg_sel != br_cfg);
  assign fifo_push  = (state == RD_RX) && !fifo_full;
  assign fifo_pop   = (state == WR_TX);

  always_comb begin
    nxt = state;
    case (state)
      CFG_LO: nxt = CFG_HI;
      CFG_HI: nxt = SETTLE;
      SETTLE: nxt = POLL;
      POLL: begin
        if (cfg_change)               nxt = CFG_LO;
        else if (rda)                 nxt = RD_RX;
        else if (tbr && !fifo_empty)  nxt = WR_TX;
      end
      RD_RX, WR_TX: nxt = SETTLE;
      default: nxt = CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CFG_LO;
      cfg_sel  <= br_cfg;
      cfg_done <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state <= nxt;
      case (state)
        CFG_HI: cfg_done <= 1'b1;
        POLL: if (cfg_change) begin
          cfg_sel  <= br_cfg;
          cfg_done <= 1'b0;
        end
        RD_RX: if (fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Reset forces the CFG_LO decode so no read strobe can escape while rst is high.
  assign dec_state = rst ? CFG_LO : state;

  always_comb begin
    req = '0;
    case (dec_state)
      CFG_LO: begin
        req.iocs  = 1'b1;
        req.addr  = ADDR_DBL;
        req.wdata = div[7:0];
      end
      CFG_HI: begin
        req.iocs  = 1'b1;
        req.addr  = ADDR_DBH;
        req.wdata = div[15:8];
      end
      RD_RX: begin
        req.iocs = 1'b1;
        req.iorw = 1'b1;
        req.addr = ADDR_BUF;
      end
      WR_TX: begin
        req.iocs  = 1'b1;
        req.addr  = ADDR_BUF;
        req.wdata = fifo_dout;
      end
      default: ;
    endcase
  end

  assign iocs    = req.iocs;
  assign iorw    = req.iorw;
  assign ioaddr  = req.addr;
  assign databus = (req.iocs && !req.iorw) ? req.wdata : 8'hzz;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (cfg_change),
    .din   (databus),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Bench for spart_echo_ctrl: SPART bus model, access log, and a TX scoreboard.
module tb_spart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] drop_cnt;
  wire  [7:0] databus;
  logic [7:0] rx_head = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        rw;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic        done;
    logic [31:0] cyc;
  } acc_t;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  acc_t       acc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];

  spart_echo_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .rda      (rda),
    .tbr      (tbr),
    .databus  (databus),
    .cfg_done (cfg_done),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPART model: answers buffer reads with the head of rx_q
  assign databus = (iocs && iorw) ? rx_head : 8'hzz;

  always @(posedge clk)
    if (!rst && iocs && iorw && ioaddr == 2'b00 && rx_q.size() > 0) void'(rx_q.pop_front());

  always @(negedge clk) begin
    rda     = (rx_q.size() != 0);
    rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Access monitor and TX scoreboard
  always @(negedge clk) begin
    acc_t a;
    if (!rst && iocs) begin
      a.rw = iorw; a.addr = ioaddr; a.data = databus; a.done = cfg_done; a.cyc = cyc;
      acc_q.push_back(a);
      if (!iorw && ioaddr == 2'b00) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, databus}, 32'h100);
        else chk("tx_data", {24'h0, databus}, {24'h0, exp_tx.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] cfg);
    br_cfg = cfg;
    tbr    = 1'b0;
    rst    = 1'b1;
    rx_q.delete();
    exp_tx.delete();
    tick();
    tick();
    acc_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_q.size() < n && b < 300) begin
      tick();
      b++;
    end
    if (acc_q.size() < n) chk("access_timeout", acc_q.size(), n);
  endtask

  task automatic chk_acc(input string nm, input int idx, input logic rw, input logic [1:0] addr,
                         input logic [7:0] data);
    if (idx >= acc_q.size()) chk({nm, "_missing"}, acc_q.size(), idx + 1);
    else chk(nm, {21'h0, acc_q[idx].rw, acc_q[idx].addr, acc_q[idx].data}, {21'h0, rw, addr, data});
  endtask

  cfg_vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b00, 8'h58, 8'h14};
    tbl[1] = '{2'b01, 8'h2C, 8'h0A};
    tbl[2] = '{2'b10, 8'h16, 8'h05};
    tbl[3] = '{2'b11, 8'h8B, 8'h02};

    // Divisor programming after reset, every baud select
    for (int i = 0; i < 4; i++) begin
      do_reset(tbl[i].cfg);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_first_decode", {iocs, iorw, ioaddr}, 4'b1010);
      wait_acc(2);
      chk_acc("cfg_lo", 0, 1'b0, 2'b10, tbl[i].lo);
      chk_acc("cfg_hi", 1, 1'b0, 2'b11, tbl[i].hi);
      chk("done_low_in_hi", acc_q[1].done, 0);
      repeat (3) tick();
      chk("cfg_done_set", cfg_done, 1);
      chk("idle_no_access", acc_q.size(), 2);
    end

    // Single echo
    do_reset(2'b01);
    wait_acc(2);
    tbr = 1'b1;
    rx_q.push_back(8'h6D);
    exp_tx.push_back(8'h6D);
    wait_acc(4);
    chk_acc("echo_read", 2, 1'b1, 2'b00, 8'h6D);
    chk_acc("echo_write", 3, 1'b0, 2'b00, 8'h6D);
    chk("echo_gap", acc_q[3].cyc - acc_q[2].cyc, 3);
    repeat (6) tick();
    chk("echo_leftover", exp_tx.size(), 0);
    chk("echo_count", acc_q.size(), 4);

    // Overflow: five bytes into a depth-4 FIFO
    do_reset(2'b01);
    wait_acc(2);
    for (int b = 1; b <= 5; b++) rx_q.push_back(8'(b));
    wait_acc(7);
    repeat (4) tick();
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_no_write", acc_q.size(), 7);
    chk_acc("ovf_read5", 6, 1'b1, 2'b00, 8'h05);
    for (int b = 1; b <= 4; b++) exp_tx.push_back(8'(b));
    tbr = 1'b1;
    wait_acc(11);
    repeat (8) tick();
    chk("ovf_leftover", exp_tx.size(), 0);
    chk("ovf_count", acc_q.size(), 11);

    // rda and tbr together: read wins
    do_reset(2'b00);
    wait_acc(2);
    rx_q.push_back(8'hA1);
    wait_acc(3);
    repeat (3) tick();
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'hB2);
    rx_q.push_back(8'hB2);
    tbr = 1'b1;
    wait_acc(6);
    chk_acc("prio_read", 3, 1'b1, 2'b00, 8'hB2);
    chk_acc("prio_write1", 4, 1'b0, 2'b00, 8'hA1);
    chk_acc("prio_write2", 5, 1'b0, 2'b00, 8'hB2);
    tbr = 1'b0;

    // br_cfg change with two bytes queued and drops already counted
    do_reset(2'b00);
    wait_acc(2);
    for (int b = 1; b <= 6; b++) rx_q.push_back(8'(b * 17));
    wait_acc(8);
    repeat (3) tick();
    chk("chg_drop_before", drop_cnt, 2);
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    tbr = 1'b1;
    wait_acc(10);
    tbr = 1'b0;
    br_cfg = 2'b11;
    wait_acc(12);
    chk_acc("chg_lo", 10, 1'b0, 2'b10, 8'h8B);
    chk_acc("chg_hi", 11, 1'b0, 2'b11, 8'h02);
    chk("chg_done_cleared", acc_q[10].done, 0);
    repeat (3) tick();
    chk("chg_cfg_done", cfg_done, 1);
    chk("chg_drop_kept", drop_cnt, 2);
    tbr = 1'b1;
    repeat (10) tick();
    chk("chg_fifo_flushed", acc_q.size(), 12);
    tbr = 1'b0;

    // Reset during WR_TX
    do_reset(2'b10);
    wait_acc(2);
    rx_q.push_back(8'h5A);
    wait_acc(3);
    tbr = 1'b1;
    begin
      int b = 0;
      while (!(iocs && !iorw && ioaddr == 2'b00) && b < 50) begin
        tick();
        b++;
      end
      chk("wrtx_reached", b < 50, 1);
    end
    rst = 1'b1;
    #1;
    chk("rst_cycle_decode", {iocs, iorw, ioaddr}, 4'b1010);
    tick();
    acc_q.delete();
    rst = 1'b0;
    wait_acc(2);
    chk_acc("abort_cfg_lo", 0, 1'b0, 2'b10, 8'h16);
    chk_acc("abort_cfg_hi", 1, 1'b0, 2'b11, 8'h05);
    repeat (8) tick();
    chk("abort_no_write", acc_q.size(), 2);
    chk("abort_drop_cnt", drop_cnt, 0);
    tbr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spart_echo_ctrl.md
SPART_ECHO_CTRL -- requirements
Module: spart_echo_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, echo buffer depth in bytes; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 br_cfg  input  2  baud select: 00=5208, 01=2604, 10=1302, 11=651 (16-bit divisor).
REQ-005 iocs  output  1  SPART chip select; high for exactly one cycle per bus access.
REQ-006 iorw  output  1  1=read, 0=write; valid only when iocs=1, otherwise 0.
REQ-007 ioaddr  output  2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high; 00 when idle.
REQ-008 rda  input  1  SPART receive-data-available.
REQ-009 tbr  input  1  SPART transmit-buffer-ready.
REQ-010 databus  inout  8  driven by the block only when iocs=1 and iorw=0, else high-Z.
REQ-011 cfg_done  output  1  high once both divisor bytes are written for the current br_cfg.
REQ-012 drop_cnt  output  8  count of received bytes discarded because the FIFO was full; saturates at 255.

Function
REQ-013 FSM states: CFG_LO, CFG_HI, SETTLE, POLL, RD_RX, WR_TX.
REQ-014 CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next state CFG_HI.
REQ-015 CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state SETTLE; cfg_done=1 from the following cycle.
REQ-016 The divisor is looked up from br_cfg registered on entry to CFG_LO, not from the live input.
REQ-017 SETTLE: one idle cycle after every bus access (iocs=0); next state POLL. This state absorbs the one-cycle latency of SPART status updates.
REQ-018 POLL: evaluated in priority order.
  - 1. Registered br_cfg differs from br_cfg: go to CFG_LO.
  - 2. rda=1: go to RD_RX.
  - 3. tbr=1 and FIFO not empty: go to WR_TX.
  - 4. Otherwise stay in POLL.
REQ-019 RD_RX: iocs=1, iorw=1, ioaddr=00.
  - databus is sampled at the closing clock edge.
  - The byte is pushed to the FIFO if the FIFO is not full; otherwise it is discarded and drop_cnt increments.
  - Next state SETTLE.
REQ-020 WR_TX: iocs=1, iorw=0, ioaddr=00, databus=FIFO head; the FIFO is popped at the closing edge; next state SETTLE.
REQ-021 rda and tbr both high in POLL: RD_RX is taken first, and WR_TX is served on a later POLL visit.
REQ-022 On a br_cfg change detected in POLL:
  - cfg_done clears in the CFG_LO cycle.
  - The FIFO is flushed (count=0) at the same edge.
  - drop_cnt is preserved.
REQ-023 A br_cfg change during any other state takes effect only at the next POLL; the in-flight access completes unchanged.
REQ-024 FIFO order is strictly first-in first-out.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - The count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop never occur in the same cycle.
REQ-025 Bytes reach the SPART unmodified, in the order received.

Reset
REQ-026 rst=1 at a clock edge produces the following state:
  - state=CFG_LO, registered br_cfg=current br_cfg.
  - FIFO empty, drop_cnt=0, cfg_done=0.
REQ-027 Reset mid-access aborts the access. The first cycle after rst deasserts is a CFG_LO write.
REQ-028 Output values in the reset cycle: iocs, iorw and ioaddr follow the CFG_LO decode; the block performs no read while rst=1.

Structure
REQ-029 Package spart_pkg holds:
  - the ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH);
  - the divisor lookup function or constants;
  - the state enum typedef.
REQ-030 One sub-module, byte_fifo (parameter DEPTH).
  - Ports: push, pop, flush, din, dout, full, empty.
  - Synchronous active-high reset.
REQ-031 The FSM and the bus-output decode are combinational from the registered state. The databus tristate is a single continuous assignment.

Verification
REQ-032 Release rst with br_cfg=01 -> cycle 1 writes 0x2C to addr 10, cycle 2 writes 0x0A to addr 11, then cfg_done=1.
REQ-033 With the SPART model returning 0x6D on rda and tbr=1 -> a read at addr 00 occurs, then after SETTLE/POLL a write of 0x6D to addr 00.
REQ-034 tbr=0, five bytes 0x01..0x05 received (FIFO_DEPTH=4):
  - drop_cnt=1.
  - Raising tbr then produces writes 0x01, 0x02, 0x03, 0x04 in that order.
REQ-035 rda=1 and tbr=1 in the same POLL cycle with a non-empty FIFO -> RD_RX precedes WR_TX.
REQ-036 br_cfg changes 00->11 while the FIFO holds 2 bytes:
  - Writes 0x8B to addr 10 and 0x02 to addr 11.
  - FIFO empty afterwards, drop_cnt unchanged.
REQ-037 rst asserted during WR_TX -> the next access after release is a CFG_LO write. databus is high-Z in every read and idle cycle.
